// File: rtl/wb_uart.sv
// wb_uart: Wishbone-attached UART with a small transmit FIFO and a
// single-byte receive holding register.
//
// Ports
//   clk_i        single clock, all logic on the rising edge
//   rst_in       synchronous active-low reset
//   cyc_i/stb_i  Wishbone cycle / strobe
//   we_i         Wishbone write enable
//   ack_o        Wishbone acknowledge (one cycle per access)
//   be_i[3:0]    byte enables (only lane 0 is meaningful)
//   adr_i        register select: 0 = DATA, 1 = STATUS
//   dat_i[31:0]  write data
//   dat_o[31:0]  read data, non-zero only in the ack cycle
//   rxd_i        asynchronous serial input, idle high
//   txd_o        serial output, idle high
//
// Bus handshake: an access is requested while cyc_i & stb_i are high and
// ack_o is low; ack_o rises the next cycle. The access takes effect (FIFO
// push, read-to-clear) only in the cycle ack_o is high, and ack_o is forced
// low afterwards, so a held strobe yields one access every two cycles.
//
// STATUS layout: bit0 tx_full, bit1 tx_idle, bit2 rx_valid, bit3 rx_overrun,
// bit4 rx_frame_err; all other bits read 0.

module wb_uart #(
    parameter int CLK_DIV    = 104,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_in,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    output logic        ack_o,
    input  logic [3:0]  be_i,
    input  logic        adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic        rxd_i,
    output logic        txd_o
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam int          CW        = AW + 1;
    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Only byte lane 0 carries data; the rest of the bus is deliberately ignored.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{be_i[3:1], dat_i[31:8]};

    // ------------------------------------------------------------------
    // Wishbone decode
    // ------------------------------------------------------------------
    logic access, wr_data, rd_data, rd_status;

    assign access    = ack_o & cyc_i & stb_i;
    assign wr_data   = access & we_i & ~adr_i & be_i[0];
    assign rd_data   = access & ~we_i & ~adr_i;
    assign rd_status = access & ~we_i & adr_i;

    always_ff @(posedge clk_i) begin
        if (!rst_in) ack_o <= 1'b0;
        else         ack_o <= cyc_i & stb_i & ~ack_o;
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_full, fifo_empty, push, pop;

    // Fullness is taken from the registered count, i.e. before this
    // cycle's pop, so a write to a full FIFO is dropped even if the
    // transmitter frees a slot in the same cycle.
    assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign push       = wr_data & ~fifo_full;

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr] <= dat_i[7:0];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    tx_state_t   tx_state, tx_state_nx;
    logic [15:0] tx_cnt, tx_cnt_nx;
    logic [2:0]  tx_bit, tx_bit_nx;
    logic [7:0]  tx_shift, tx_shift_nx;
    logic        tx_idle;

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_state_nx;
            tx_cnt   <= tx_cnt_nx;
            tx_bit   <= tx_bit_nx;
            tx_shift <= tx_shift_nx;
        end
    end

    always_comb begin
        tx_state_nx = tx_state;
        tx_cnt_nx   = tx_cnt + 16'd1;
        tx_bit_nx   = tx_bit;
        tx_shift_nx = tx_shift;
        pop         = 1'b0;
        txd_o       = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_nx = '0;
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    tx_shift_nx = fifo_mem[rd_ptr];
                    tx_state_nx = TX_START;
                end
            end
            TX_START: begin
                txd_o = 1'b0;
                if (tx_cnt == DIV_LAST) begin
                    tx_cnt_nx   = '0;
                    tx_bit_nx   = '0;
                    tx_state_nx = TX_DATA;
                end
            end
            TX_DATA: begin
                txd_o = tx_shift[0];
                if (tx_cnt == DIV_LAST) begin
                    tx_cnt_nx   = '0;
                    tx_shift_nx = {1'b0, tx_shift[7:1]};
                    tx_bit_nx   = tx_bit + 3'd1;
                    if (tx_bit == 3'd7) tx_state_nx = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_cnt == DIV_LAST) begin
                    tx_cnt_nx = '0;
                    // Chain straight into the next start bit when more
                    // data is waiting, so frames are contiguous.
                    if (!fifo_empty) begin
                        pop         = 1'b1;
                        tx_shift_nx = fifo_mem[rd_ptr];
                        tx_state_nx = TX_START;
                    end else begin
                        tx_state_nx = TX_IDLE;
                    end
                end
            end
            default: tx_state_nx = TX_IDLE;
        endcase
    end

    assign tx_idle = fifo_empty & (tx_state == TX_IDLE);

    // ------------------------------------------------------------------
    // RX synchronizer and edge detect (rx_prev is the previous synced value)
    // ------------------------------------------------------------------
    logic rx_s1, rx_s2, rx_prev;

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rxd_i;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // ------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------
    rx_state_t   rx_state, rx_state_nx;
    logic [15:0] rx_cnt, rx_cnt_nx;
    logic [2:0]  rx_bit, rx_bit_nx;
    logic [7:0]  rx_shift, rx_shift_nx;
    logic        rx_good, rx_bad;

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_nx;
            rx_cnt   <= rx_cnt_nx;
            rx_bit   <= rx_bit_nx;
            rx_shift <= rx_shift_nx;
        end
    end

    always_comb begin
        rx_state_nx = rx_state;
        rx_cnt_nx   = rx_cnt + 16'd1;
        rx_bit_nx   = rx_bit;
        rx_shift_nx = rx_shift;
        rx_good     = 1'b0;
        rx_bad      = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_nx = '0;
                if (rx_prev && !rx_s2) rx_state_nx = RX_START;
            end
            RX_START: begin
                // Half a bit in: a line back high means it was a glitch.
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_nx   = '0;
                    rx_bit_nx   = '0;
                    rx_state_nx = rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == DIV_LAST) begin
                    rx_cnt_nx   = '0;
                    rx_shift_nx = {rx_s2, rx_shift[7:1]};
                    rx_bit_nx   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state_nx = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt == DIV_LAST) begin
                    rx_cnt_nx   = '0;
                    rx_state_nx = RX_IDLE;
                    if (rx_s2) rx_good = 1'b1;
                    else       rx_bad  = 1'b1;
                end
            end
            default: rx_state_nx = RX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // RX holding register and sticky flags
    // ------------------------------------------------------------------
    logic [7:0] rx_byte;
    logic       rx_valid, rx_overrun, rx_frame_err;

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            rx_byte      <= '0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (rx_good) rx_byte <= rx_shift;
            // A byte landing in the same cycle as a DATA read survives the
            // read; overrun only counts an unread byte being replaced.
            rx_valid     <= rx_good | (rx_valid & ~rd_data);
            rx_overrun   <= ~rd_data & (rx_overrun | (rx_good & rx_valid));
            rx_frame_err <= rx_bad | (rx_frame_err & ~rd_status);
        end
    end

    // ------------------------------------------------------------------
    // Read data
    // ------------------------------------------------------------------
    always_comb begin
        dat_o = '0;
        if (ack_o && !we_i) begin
            if (adr_i) dat_o = {27'h0, rx_frame_err, rx_overrun, rx_valid, tx_idle, fifo_full};
            else       dat_o = {24'h0, rx_byte};
        end
    end

endmodule

// File: tb/tb_wb_uart.sv
// tb_wb_uart: self-checking bench for wb_uart with CLK_DIV = 4, FIFO_DEPTH = 4.
// A serial monitor captures every transmitted frame as a 40-sample waveform,
// which is compared against the ideal waveform built from the byte. Received
// bytes are checked against a register-level model of rx_byte and its flags.

module tb_wb_uart;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc   = 1'b0;
    logic        stb   = 1'b0;
    logic        we    = 1'b0;
    logic        adr   = 1'b0;
    logic [3:0]  be    = 4'h0;
    logic [31:0] dat_w = 32'h0;
    logic        rxd   = 1'b1;
    logic        ack;
    logic [31:0] dat_r;
    logic        txd;

    int n_pass  = 0;
    int n_total = 0;
    int cycle   = 0;

    bit          mon_en = 1'b0;
    logic [39:0] mon_wave[$];
    int          mon_start[$];
    logic [7:0]  exp_q[$];

    // Receive-side model
    logic [7:0] m_byte  = 8'h0;
    bit         m_valid = 1'b0;
    bit         m_ovr   = 1'b0;
    bit         m_ferr  = 1'b0;

    wb_uart #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i  (clk),
        .rst_in (rst_n),
        .cyc_i  (cyc),
        .stb_i  (stb),
        .we_i   (we),
        .ack_o  (ack),
        .be_i   (be),
        .adr_i  (adr),
        .dat_i  (dat_w),
        .dat_o  (dat_r),
        .rxd_i  (rxd),
        .txd_o  (txd)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #600000;
        $display("FAIL watchdog: run did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- serial monitor ----------------
    initial begin : tx_monitor
        logic [39:0] w;
        int          st;
        forever begin
            @(posedge clk); #2;
            if (mon_en && txd === 1'b0) begin
                st = cycle;
                w  = '0;
                for (int i = 1; i < 40; i++) begin
                    @(posedge clk); #2;
                    w[i] = txd;
                end
                mon_wave.push_back(w);
                mon_start.push_back(st);
            end
        end
    end

    // Ideal frame: 4 samples low, 8 data bits LSB first 4 samples each, 4 high.
    function automatic logic [39:0] frame_wave(input logic [7:0] b);
        logic [39:0] w;
        for (int i = 0; i < 40; i++) begin
            if (i < 4)       w[i] = 1'b0;
            else if (i < 36) w[i] = b[3'((i - 4) / 4)];
            else             w[i] = 1'b1;
        end
        return w;
    endfunction

    function automatic logic [31:0] exp_status(input logic full, input logic idle);
        return {27'h0, m_ferr, m_ovr, m_valid, idle, full};
    endfunction

    // ---------------- drivers ----------------
    // One Wishbone access; returns ack as seen one cycle after the request and
    // one cycle after that, plus the read data in the ack cycle.
    task automatic bus(input logic w, input logic a, input logic [3:0] b, input logic [31:0] d,
                       output logic ack1, output logic ack2, output logic [31:0] rd);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; be = b; dat_w = d;
        @(posedge clk); #1;
        ack1 = ack;
        rd   = dat_r;
        @(posedge clk); #1;
        ack2 = ack;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; be = 4'h0; dat_w = 32'h0;
    endtask

    task automatic wait_tx_idle(output bit ok);
        logic a1, a2;
        logic [31:0] r;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            bus(1'b0, 1'b1, 4'hF, 32'h0, a1, a2, r);
            if (r[1] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop);
        rxd = 1'b0;
        repeat (DIV) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (DIV) @(posedge clk);
            #1;
        end
        rxd = stop;
        repeat (DIV) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic model_frame(input logic [7:0] b, input bit stop);
        if (stop) begin
            if (m_valid) m_ovr = 1'b1;
            m_byte  = b;
            m_valid = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    task automatic model_rd_data(output logic [31:0] e);
        e       = {24'h0, m_byte};
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic model_rd_status(output logic [31:0] e);
        e      = exp_status(1'b0, 1'b1);
        m_ferr = 1'b0;
    endtask

    task automatic model_reset();
        m_byte = 8'h0; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic a1, a2;
        logic [31:0] r;
        rst_n = 1'b0;
        rxd   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (ack !== 1'b0) $display("FAIL reset_ack: got %b expected 0", ack); else n_pass++;
        n_total++; if (dat_r !== 32'h0) $display("FAIL reset_dat: got %h expected 0", dat_r); else n_pass++;
        n_total++; if (txd !== 1'b1) $display("FAIL reset_txd: got %b expected 1", txd); else n_pass++;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        bus(1'b0, 1'b1, 4'hF, 32'h0, a1, a2, r);
        n_total++; if (r !== 32'h2) $display("FAIL reset_status: got %h expected 00000002", r); else n_pass++;
        bus(1'b0, 1'b0, 4'hF, 32'h0, a1, a2, r);
        n_total++; if (r !== 32'h0) $display("FAIL reset_data: got %h expected 0", r); else n_pass++;
    endtask

    task automatic test_tx_single();
        logic a1, a2;
        logic [31:0] r;
        bit ok;
        mon_wave.delete(); mon_start.delete();
        mon_en = 1'b1;
        // Lane 0 disabled, then a STATUS write: neither may start a frame.
        bus(1'b1, 1'b0, 4'hE, 32'hAA, a1, a2, r);
        bus(1'b1, 1'b1, 4'hF, 32'hFFFF_FFFF, a1, a2, r);
        repeat (50) @(posedge clk);
        #1;
        n_total++; if (mon_wave.size() != 0) $display("FAIL tx_no_effect_frames: got %0d expected 0", mon_wave.size()); else n_pass++;
        bus(1'b0, 1'b1, 4'hF, 32'h0, a1, a2, r);
        n_total++; if (r !== 32'h2) $display("FAIL tx_no_effect_status: got %h expected 00000002", r); else n_pass++;

        bus(1'b1, 1'b0, 4'h1, 32'h1234_5655, a1, a2, r);
        n_total++; if (a1 !== 1'b1) $display("FAIL ack_latency: got %b expected 1", a1); else n_pass++;
        n_total++; if (a2 !== 1'b0) $display("FAIL ack_drop: got %b expected 0", a2); else n_pass++;
        wait_tx_idle(ok);
        n_total++; if (ok !== 1'b1) $display("FAIL tx55_idle_timeout: got %b expected 1", ok); else n_pass++;
        n_total++; if (mon_wave.size() != 1) $display("FAIL tx55_frames: got %0d expected 1", mon_wave.size()); else n_pass++;
        if (mon_wave.size() > 0) begin
            n_total++;
            if (mon_wave[0] !== frame_wave(8'h55))
                $display("FAIL tx55_wave: got %h expected %h", mon_wave[0], frame_wave(8'h55));
            else n_pass++;
        end
        bus(1'b0, 1'b1, 4'hF, 32'h0, a1, a2, r);
        n_total++; if (r[1] !== 1'b1) $display("FAIL tx55_status_idle: got %b expected 1", r[1]); else n_pass++;
    endtask

    task automatic test_fifo_full();
        logic a1, a2;
        logic [31:0] r;
        bit ok;
        mon_wave.delete(); mon_start.delete();
        for (int i = 1; i <= 5; i++) bus(1'b1, 1'b0, 4'hF, 32'(i), a1, a2, r);
        bus(1'b0, 1'b1, 4'hF, 32'h0, a1, a2, r);
        // One byte is already in flight, four are queued: full, not idle.
        n_total++; if (r[1:0] !== 2'b01) $display("FAIL fifo_full_status: got %b expected 01", r[1:0]); else n_pass++;
        bus(1'b1, 1'b0, 4'hF, 32'h6, a1, a2, r);
        n_total++; if (a1 !== 1'b1) $display("FAIL fifo_drop_ack: got %b expected 1", a1); else n_pass++;
        wait_tx_idle(ok);
        n_total++; if (ok !== 1'b1) $display("FAIL fifo_idle_timeout: got %b expected 1", ok); else n_pass++;
        n_total++; if (mon_wave.size() != 5) $display("FAIL fifo_frames: got %0d expected 5", mon_wave.size()); else n_pass++;
        for (int i = 0; i < 5 && i < mon_wave.size(); i++) begin
            n_total++;
            if (mon_wave[i] !== frame_wave(8'(i + 1)))
                $display("FAIL fifo_wave_%0d: got %h expected %h", i, mon_wave[i], frame_wave(8'(i + 1)));
            else n_pass++;
            if (i > 0) begin
                n_total++;
                if (mon_start[i] - mon_start[i-1] != 40)
                    $display("FAIL fifo_gap_%0d: got %0d expected 40", i, mon_start[i] - mon_start[i-1]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_tx_random();
        logic a1, a2;
        logic [31:0] r;
        logic [7:0] b;
        bit ok;
        int n;
        for (int round = 0; round < 3; round++) begin
            mon_wave.delete(); mon_start.delete(); exp_q.delete();
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom_range(0, 255));
                exp_q.push_back(b);
                bus(1'b1, 1'b0, 4'hF, {$urandom, b} >> 0, a1, a2, r);
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #0;
            end
            wait_tx_idle(ok);
            n_total++; if (ok !== 1'b1) $display("FAIL txr_idle_timeout_%0d: got %b expected 1", round, ok); else n_pass++;
            n_total++;
            if (mon_wave.size() != n) $display("FAIL txr_frames_%0d: got %0d expected %0d", round, mon_wave.size(), n);
            else n_pass++;
            while (exp_q.size() > 0 && mon_wave.size() > 0) begin
                b = exp_q.pop_front();
                n_total++;
                if (mon_wave[0] !== frame_wave(b))
                    $display("FAIL txr_wave_%0d: got %h expected %h", round, mon_wave[0], frame_wave(b));
                else n_pass++;
                void'(mon_wave.pop_front());
            end
        end
        mon_en = 1'b0;
    endtask

    task automatic test_rx_basic();
        logic a1, a2;
        logic [31:0] r, e;
        send_frame(8'hA3, 1'b1); model_frame(8'hA3, 1'b1);
        // tx_idle (bit1) is also set: the transmitter has nothing to do.
        bus(1'b0, 1'b1, 4'hF, 32'h0, a1, a2, r); model_rd_status(e);
        n_total++; if (r !== e) $display("FAIL rx_a3_status: got %h expected %h", r, e); else n_pass++;
        bus(1'b0, 1'b0, 4'hF, 32'h0, a1, a2, r); model_rd_data(e);
        n_total++; if (r !== e) $display("FAIL rx_a3_data: got %h expected %h", r, e); else n_pass++;
        bus(1'b0, 1'b1, 4'hF, 32'h0, a1, a2, r); model_rd_status(e);
        n_total++; if (r !== e) $display("FAIL rx_a3_status_after: got %h expected %h", r, e); else n_pass++;
    endtask

    task automatic test_rx_overrun();
        logic a1, a2;
        logic [31:0] r, e;
        send_frame(8'h11, 1'b1); model_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1); model_frame(8'h22, 1'b1);
        bus(1'b0, 1'b1, 4'hF, 32'h0, a1, a2, r); model_rd_status(e);
        n_total++; if (r !== e) $display("FAIL ovr_status: got %h expected %h", r, e); else n_pass++;
        bus(1'b0, 1'b0, 4'hF, 32'h0, a1, a2, r); model_rd_data(e);
        n_total++; if (r !== e) $display("FAIL ovr_data: got %h expected %h", r, e); else n_pass++;
        send_frame(8'h33, 1'b1); model_frame(8'h33, 1'b1);
        send_frame(8'h5A, 1'b0); model_frame(8'h5A, 1'b0);
        bus(1'b0, 1'b1, 4'hF, 32'h0, a1, a2, r); model_rd_status(e);
        n_total++; if (r !== e) $display("FAIL ferr_status: got %h expected %h", r, e); else n_pass++;
        bus(1'b0, 1'b0, 4'hF, 32'h0, a1, a2, r); model_rd_data(e);
        n_total++; if (r !== e) $display("FAIL ferr_data: got %h expected %h", r, e); else n_pass++;
        bus(1'b0, 1'b1, 4'hF, 32'h0, a1, a2, r); model_rd_status(e);
        n_total++; if (r !== e) $display("FAIL ferr_cleared: got %h expected %h", r, e); else n_pass++;
    endtask

    // A DATA read whose ack cycle coincides with the stop-bit sample of the
    // next byte: the read sees the old byte, the new byte stays valid.
    task automatic test_rx_collide();
        logic a1, a2;
        logic [31:0] r, e, rc, ec;
        send_frame(8'h3C, 1'b1); model_frame(8'h3C, 1'b1);
        send_frame(8'h5D, 1'b1); model_frame(8'h5D, 1'b1);
        fork
            send_frame(8'h96, 1'b1);
            begin
                repeat (39) @(posedge clk);
                #1;
                bus(1'b0, 1'b0, 4'hF, 32'h0, a1, a2, rc);
            end
        join
        model_rd_data(ec);
        model_frame(8'h96, 1'b1);
        n_total++; if (rc !== ec) $display("FAIL collide_read: got %h expected %h", rc, ec); else n_pass++;
        bus(1'b0, 1'b1, 4'hF, 32'h0, a1, a2, r); model_rd_status(e);
        n_total++; if (r !== e) $display("FAIL collide_status: got %h expected %h", r, e); else n_pass++;
        bus(1'b0, 1'b0, 4'hF, 32'h0, a1, a2, r); model_rd_data(e);
        n_total++; if (r !== e) $display("FAIL collide_data: got %h expected %h", r, e); else n_pass++;
    endtask

    task automatic test_rx_random();
        logic a1, a2;
        logic [31:0] r, e;
        logic [7:0] b;
        bit stop;
        int act;
        for (int i = 0; i < 8; i++) begin
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            send_frame(b, stop); model_frame(b, stop);
            act = $urandom_range(0, 2);
            if (act == 1) begin
                bus(1'b0, 1'b0, 4'hF, 32'h0, a1, a2, r); model_rd_data(e);
                n_total++; if (r !== e) $display("FAIL rxr_data_%0d: got %h expected %h", i, r, e); else n_pass++;
            end else if (act == 2) begin
                bus(1'b0, 1'b1, 4'hF, 32'h0, a1, a2, r); model_rd_status(e);
                n_total++; if (r !== e) $display("FAIL rxr_status_%0d: got %h expected %h", i, r, e); else n_pass++;
            end
        end
        bus(1'b0, 1'b1, 4'hF, 32'h0, a1, a2, r); model_rd_status(e);
        n_total++; if (r !== e) $display("FAIL rxr_status_end: got %h expected %h", r, e); else n_pass++;
        bus(1'b0, 1'b0, 4'hF, 32'h0, a1, a2, r); model_rd_data(e);
        n_total++; if (r !== e) $display("FAIL rxr_data_end: got %h expected %h", r, e); else n_pass++;
    endtask

    task automatic test_glitch();
        logic a1, a2;
        logic [31:0] r, e;
        rxd = 1'b0;
        @(posedge clk); #1;
        rxd = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        bus(1'b0, 1'b1, 4'hF, 32'h0, a1, a2, r); model_rd_status(e);
        n_total++; if (r !== e) $display("FAIL glitch_status: got %h expected %h", r, e); else n_pass++;
    endtask

    task automatic test_reset_mid_tx();
        logic a1, a2;
        logic [31:0] r;
        int lows;
        mon_en = 1'b0;
        bus(1'b1, 1'b0, 4'hF, 32'hC6, a1, a2, r);
        bus(1'b1, 1'b0, 4'hF, 32'h81, a1, a2, r);  // stays queued behind 0xC6
        repeat (15) @(posedge clk);
        #1;
        // Inside data bit 3 of 0xC6, which is 0.
        n_total++; if (txd !== 1'b0) $display("FAIL rst_pre_bit3: got %b expected 0", txd); else n_pass++;
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_total++; if (txd !== 1'b1) $display("FAIL rst_txd_high: got %b expected 1", txd); else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        lows = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (txd !== 1'b1) lows++;
        end
        n_total++; if (lows != 0) $display("FAIL rst_fifo_lost: got %0d low cycles expected 0", lows); else n_pass++;
        bus(1'b0, 1'b1, 4'hF, 32'h0, a1, a2, r);
        n_total++; if (r !== 32'h2) $display("FAIL rst_status: got %h expected 00000002", r); else n_pass++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_tx_single();
        test_fifo_full();
        test_tx_random();
        test_rx_basic();
        test_rx_overrun();
        test_rx_collide();
        test_rx_random();
        test_glitch();
        test_reset_mid_tx();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
